hazard_ctrl_unit: RTL and testbench

//  Parametrised successor to the pipeline hazard detector; sits between the IF/ID and ID/EX latches.

---
 rtl/hazard_ctrl_unit.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller between the IF/ID and ID/EX latches.
// It detects load-use hazards and taken branches, and holds stalls or flushes across several cycles.
module hazard_ctrl_unit #(
    parameter int REG_W           = 5,
    parameter int LOAD_STALL      = 1,
    parameter int FLUSH_DEPTH     = 1,
    parameter bit ZERO_REG_EXEMPT = 1'b1
) (
    input  logic             inClk,
    input  logic             inReset,
    input  logic             inMemRead,
    input  logic             inBranch,
    input  logic             inZeroAlu,
    input  logic             inBranchNE,
    input  logic [REG_W-1:0] inID_EXRt,
    input  logic [REG_W-1:0] inIF_IDRs,
    input  logic [REG_W-1:0] inIF_IDRt,
    input  logic             inIF_IDUsesRt,
    output logic             outPCWrite,
    output logic             outIF_IDWrite,
    output logic             outIF_Flush,
    output logic             outCtrlEnable,
    output logic             outBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } stateT;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_FLUSH  = 2'd2
    } modeT;

    // The first cycle of each action is issued from IDLE, so the counters only cover the remaining cycles.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
    localparam bit         STALL_MULTI  = (LOAD_STALL > 1);
    localparam bit         FLUSH_MULTI  = (FLUSH_DEPTH > 1);

    stateT      st;
    stateT      stNext;
    logic [2:0] cnt;
    logic [2:0] cntNext;
    modeT       mode;

    logic taken;
    logic exemptLoad;
    logic srcMatch;
    logic luh;

    assign taken      = inBranch & (inBranchNE ? ~inZeroAlu : inZeroAlu);
    assign exemptLoad = ZERO_REG_EXEMPT & (inID_EXRt == '0);
    assign srcMatch   = (inID_EXRt == inIF_IDRs) | (inIF_IDUsesRt & (inID_EXRt == inIF_IDRt));
    assign luh        = inMemRead & ~exemptLoad & srcMatch;

    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            st  <= stNext;
            cnt <= cntNext;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stNext  = st;
        cntNext = cnt;
        mode    = MODE_NORMAL;

        unique case (st)
            IDLE: begin
                if (taken) begin
                    mode = MODE_FLUSH;
                    if (FLUSH_MULTI) begin
                        stNext  = FLUSH;
                        cntNext = FLUSH_RELOAD;
                    end
                end else if (luh) begin
                    mode = MODE_HOLD;
                    if (STALL_MULTI) begin
                        stNext  = STALL;
                        cntNext = STALL_RELOAD;
                    end
                end
            end

            STALL: begin
                // A taken branch squashes the stalled load's consumer, so the stall is abandoned.
                if (taken) begin
                    mode = MODE_FLUSH;
                    if (FLUSH_MULTI) begin
                        stNext  = FLUSH;
                        cntNext = FLUSH_RELOAD;
                    end else begin
                        stNext  = IDLE;
                        cntNext = '0;
                    end
                end else begin
                    mode    = MODE_HOLD;
                    cntNext = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        stNext = IDLE;
                    end
                end
            end

            FLUSH: begin
                mode = MODE_FLUSH;
                if (taken) begin
                    cntNext = FLUSH_RELOAD;
                end else begin
                    cntNext = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        stNext = IDLE;
                    end
                end
            end

            default: begin
                stNext  = IDLE;
                cntNext = '0;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, independent of the registered state.
    always_comb begin
        outPCWrite    = 1'b0;
        outIF_IDWrite = 1'b0;
        outIF_Flush   = 1'b0;
        outCtrlEnable = 1'b0;
        outBusy       = 1'b0;

        if (!inReset) begin
            outBusy = (st != IDLE);
            unique case (mode)
                MODE_HOLD: begin
                    outPCWrite    = 1'b0;
                    outIF_IDWrite = 1'b0;
                    outIF_Flush   = 1'b0;
                    outCtrlEnable = 1'b0;
                end
                MODE_FLUSH: begin
                    outPCWrite    = 1'b1;
                    outIF_IDWrite = 1'b1;
                    outIF_Flush   = 1'b1;
                    outCtrlEnable = 1'b1;
                end
                default: begin
                    outPCWrite    = 1'b1;
                    outIF_IDWrite = 1'b1;
                    outIF_Flush   = 1'b0;
                    outCtrlEnable = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: four parameter sets share one stimulus stream,
// and a remaining-cycles reference model predicts each instance's outputs.
module tb_hazard_ctrl_unit;

    localparam int NCFG = 4;
    localparam int LS_T [NCFG] = '{1, 3, 4, 4};
    localparam int FD_T [NCFG] = '{1, 2, 1, 3};
    localparam int ZX_T [NCFG] = '{1, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       memRead = 1'b0;
    logic       branch = 1'b0;
    logic       zeroAlu = 1'b0;
    logic       branchNE = 1'b0;
    logic [4:0] exRt = '0;
    logic [4:0] rs = '0;
    logic [4:0] rt = '0;
    logic       usesRt = 1'b0;

    logic pcw  [NCFG];
    logic ifw  [NCFG];
    logic fl   [NCFG];
    logic ce   [NCFG];
    logic busy [NCFG];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Expected outputs for all instances of one cycle, 5 bits each: {PCWrite, IF_IDWrite, Flush, CtrlEnable, Busy}.
    logic [NCFG*5-1:0] sbQ [$];

    int stallLeft [NCFG];
    int flushLeft [NCFG];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_W(5), .LOAD_STALL(LS_T[0]), .FLUSH_DEPTH(FD_T[0]), .ZERO_REG_EXEMPT(ZX_T[0] != 0)) u0 (
        .inClk(clk), .inReset(rst), .inMemRead(memRead), .inBranch(branch), .inZeroAlu(zeroAlu),
        .inBranchNE(branchNE), .inID_EXRt(exRt), .inIF_IDRs(rs), .inIF_IDRt(rt), .inIF_IDUsesRt(usesRt),
        .outPCWrite(pcw[0]), .outIF_IDWrite(ifw[0]), .outIF_Flush(fl[0]), .outCtrlEnable(ce[0]), .outBusy(busy[0]));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_STALL(LS_T[1]), .FLUSH_DEPTH(FD_T[1]), .ZERO_REG_EXEMPT(ZX_T[1] != 0)) u1 (
        .inClk(clk), .inReset(rst), .inMemRead(memRead), .inBranch(branch), .inZeroAlu(zeroAlu),
        .inBranchNE(branchNE), .inID_EXRt(exRt), .inIF_IDRs(rs), .inIF_IDRt(rt), .inIF_IDUsesRt(usesRt),
        .outPCWrite(pcw[1]), .outIF_IDWrite(ifw[1]), .outIF_Flush(fl[1]), .outCtrlEnable(ce[1]), .outBusy(busy[1]));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_STALL(LS_T[2]), .FLUSH_DEPTH(FD_T[2]), .ZERO_REG_EXEMPT(ZX_T[2] != 0)) u2 (
        .inClk(clk), .inReset(rst), .inMemRead(memRead), .inBranch(branch), .inZeroAlu(zeroAlu),
        .inBranchNE(branchNE), .inID_EXRt(exRt), .inIF_IDRs(rs), .inIF_IDRt(rt), .inIF_IDUsesRt(usesRt),
        .outPCWrite(pcw[2]), .outIF_IDWrite(ifw[2]), .outIF_Flush(fl[2]), .outCtrlEnable(ce[2]), .outBusy(busy[2]));

    hazard_ctrl_unit #(.REG_W(5), .LOAD_STALL(LS_T[3]), .FLUSH_DEPTH(FD_T[3]), .ZERO_REG_EXEMPT(ZX_T[3] != 0)) u3 (
        .inClk(clk), .inReset(rst), .inMemRead(memRead), .inBranch(branch), .inZeroAlu(zeroAlu),
        .inBranchNE(branchNE), .inID_EXRt(exRt), .inIF_IDRs(rs), .inIF_IDRt(rt), .inIF_IDUsesRt(usesRt),
        .outPCWrite(pcw[3]), .outIF_IDWrite(ifw[3]), .outIF_Flush(fl[3]), .outCtrlEnable(ce[3]), .outBusy(busy[3]));

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got {pcw,ifw,flush,ce,busy}=%b required %b", name, cycle, got, want);
        end
    endtask

    // Reference model: each instance owes some number of further bubble or flush cycles.
    task automatic modelStep(input bit r, input bit m, input bit b, input bit z, input bit ne,
                             input logic [4:0] x, input logic [4:0] s, input logic [4:0] t, input bit u,
                             output logic [NCFG*5-1:0] expAll);
        bit takenV, depV, luhV, busyV;
        logic [3:0] modeBits;
        expAll = '0;
        takenV = b && (ne ? !z : z);
        depV   = (x == s) || (u && (x == t));
        for (int k = 0; k < NCFG; k++) begin
            if (r) begin
                stallLeft[k] = 0;
                flushLeft[k] = 0;
                expAll[k*5 +: 5] = 5'b00000;
            end else begin
                luhV  = m && !((ZX_T[k] != 0) && (x == 5'd0)) && depV;
                busyV = (stallLeft[k] > 0) || (flushLeft[k] > 0);
                if (takenV) begin
                    modeBits     = 4'b1111;
                    flushLeft[k] = FD_T[k] - 1;
                    stallLeft[k] = 0;
                end else if (flushLeft[k] > 0) begin
                    modeBits = 4'b1111;
                    flushLeft[k]--;
                end else if (stallLeft[k] > 0) begin
                    modeBits = 4'b0000;
                    stallLeft[k]--;
                end else if (luhV) begin
                    modeBits     = 4'b0000;
                    stallLeft[k] = LS_T[k] - 1;
                end else begin
                    modeBits = 4'b1101;
                end
                expAll[k*5 +: 5] = {modeBits, busyV};
            end
        end
    endtask

    task automatic drive(input bit r, input bit m, input bit b, input bit z, input bit ne,
                         input logic [4:0] x, input logic [4:0] s, input logic [4:0] t, input bit u);
        logic [NCFG*5-1:0] e;
        @(posedge clk);
        #1;
        rst = r; memRead = m; branch = b; zeroAlu = z; branchNE = ne;
        exRt = x; rs = s; rt = t; usesRt = u;
        modelStep(r, m, b, z, ne, x, s, t, u, e);
        sbQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0);
    endtask

    // Monitor: compares each instance's outputs mid-cycle against the oldest pending expectation.
    always @(negedge clk) begin
        logic [NCFG*5-1:0] e;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check("cfg0", {pcw[0], ifw[0], fl[0], ce[0], busy[0]}, e[0 +: 5]);
            check("cfg1", {pcw[1], ifw[1], fl[1], ce[1], busy[1]}, e[5 +: 5]);
            check("cfg2", {pcw[2], ifw[2], fl[2], ce[2], busy[2]}, e[10 +: 5]);
            check("cfg3", {pcw[3], ifw[3], fl[3], ce[3], busy[3]}, e[15 +: 5]);
            cycle++;
        end
    end

    initial begin
        for (int k = 0; k < NCFG; k++) begin
            stallLeft[k] = 0;
            flushLeft[k] = 0;
        end

        // Reset held for two cycles, then release.
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        drive(1, 1, 1, 1, 0, 5'd5, 5'd5, 5'd5, 1);
        idle(2);

        // Single load-use hazard on rs.
        drive(0, 1, 0, 0, 0, 5'd5, 5'd5, 5'd9, 0);
        idle(5);

        // Register-0 exemption and the rt-use qualifier.
        drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd3, 0);
        idle(5);
        drive(0, 1, 0, 0, 0, 5'd5, 5'd1, 5'd5, 0);
        idle(1);
        drive(0, 1, 0, 0, 0, 5'd5, 5'd1, 5'd5, 1);
        idle(5);

        // Taken bne, then a not-taken bne, then a taken beq.
        drive(0, 0, 1, 0, 1, 5'd0, 5'd1, 5'd2, 0);
        idle(4);
        drive(0, 0, 1, 1, 1, 5'd0, 5'd1, 5'd2, 0);
        idle(1);
        drive(0, 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0);
        idle(4);

        // Taken beq arriving in the second stall cycle aborts the stall.
        drive(0, 1, 0, 0, 0, 5'd7, 5'd7, 5'd0, 0);
        drive(0, 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0);
        idle(5);

        // Back-to-back taken branches reload the flush.
        drive(0, 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0);
        drive(0, 0, 1, 0, 1, 5'd0, 5'd1, 5'd2, 0);
        idle(5);

        // Reset in the second stall cycle clears everything.
        drive(0, 1, 0, 0, 0, 5'd7, 5'd7, 5'd0, 0);
        drive(1, 1, 0, 0, 0, 5'd7, 5'd7, 5'd0, 0);
        idle(3);

        // Randomised traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0,
                  1'($urandom),
                  1'($urandom),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  1'($urandom));
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
